// File: rtl/lane_arbiter_8b.sv
// lane_arbiter_8b
//   Round-robin arbiter that shares one 8b->32b word packer between
//   NUM_LANES byte sources. A grant is held for BYTES_PER_WORD consecutive
//   bytes so a packed word never mixes lanes. Runs in the clk_4f domain.
//
// Ports
//   clk_4f      byte-rate clock
//   reset       synchronous, active-high reset
//   lane_valid  per-lane byte valid
//   lane_data   lane i byte on bits [8i+7:8i]
//   lane_ready  one-hot registered grant (byte taken when ready && valid)
//   valid_out   byte valid to packer
//   data_out    byte to packer
//   lane_sel    lane index of the byte on data_out
//   word_done   1-cycle pulse with the last byte of a complete word
//   word_abort  1-cycle pulse when the granted lane drops valid mid-word
//
// Build option
//   FIXED_PRIO_EN  when defined, every search starts at lane 0 (lowest index
//                  wins) instead of at the round-robin pointer.

module lane_arbiter_8b #(
  parameter int NUM_LANES      = 4,
  parameter int BYTES_PER_WORD = 4,
  parameter int SEL_W          = 2
) (
  input  logic                   clk_4f,
  input  logic                   reset,
  input  logic [NUM_LANES-1:0]   lane_valid,
  input  logic [NUM_LANES*8-1:0] lane_data,
  output logic [NUM_LANES-1:0]   lane_ready,
  output logic                   valid_out,
  output logic [7:0]             data_out,
  output logic [SEL_W-1:0]       lane_sel,
  output logic                   word_done,
  output logic                   word_abort
);

  localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

`ifdef FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [NUM_LANES-1:0] ready_q, ready_d;
  logic                 vout_q, vout_d;
  logic [7:0]           dout_q, dout_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;

  logic [SEL_W:0]       srch_idle;
  logic [SEL_W:0]       srch_wrap;
  logic [SEL_W-1:0]     gnt_next;

  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] l);
    return (int'(l) == NUM_LANES - 1) ? '0 : l + SEL_W'(1);
  endfunction

  // Returns {found, index} of the first valid lane at or after start,
  // wrapping modulo NUM_LANES.
  function automatic logic [SEL_W:0] search(input logic [NUM_LANES-1:0] v,
                                            input logic [SEL_W-1:0]     start);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = start;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (!found && v[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = next_lane(cand);
    end
    return {found, idx};
  endfunction

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ready_q <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    ready_d  = ready_q;
    vout_d   = 1'b0;
    dout_d   = dout_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    gnt_next = next_lane(gnt_q);

    // Both searches use this cycle's lane_valid; the wrap search lets the
    // next grant land on the same edge as the last byte, so back-to-back
    // words carry no bubble.
    srch_idle = search(lane_valid, FIXED_PRIO ? '0 : ptr_q);
    srch_wrap = search(lane_valid, FIXED_PRIO ? '0 : gnt_next);

    case (state_q)
      IDLE: begin
        if (srch_idle[SEL_W]) begin
          ready_d = NUM_LANES'(1) << srch_idle[SEL_W-1:0];
          gnt_d   = srch_idle[SEL_W-1:0];
          state_d = GRANT;
        end else begin
          ready_d = '0;
        end
      end

      GRANT: begin
        if (lane_valid[gnt_q]) begin
          vout_d = 1'b1;
          dout_d = lane_data[{gnt_q, 3'b000} +: 8];
          sel_d  = gnt_q;
          if (cnt_q == CNT_LAST) begin
            done_d = 1'b1;
            cnt_d  = '0;
            ptr_d  = gnt_next;
            if (srch_wrap[SEL_W]) begin
              ready_d = NUM_LANES'(1) << srch_wrap[SEL_W-1:0];
              gnt_d   = srch_wrap[SEL_W-1:0];
            end else begin
              ready_d = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Dropping valid before any byte of the word is a plain release;
          // dropping it part-way through reports an abort.
          abort_d = (cnt_q != '0);
          cnt_d   = '0;
          ptr_d   = gnt_next;
          ready_d = '0;
          state_d = IDLE;
        end
      end

      default: begin
        ready_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign lane_ready = ready_q;
  assign valid_out  = vout_q;
  assign data_out   = dout_q;
  assign lane_sel   = sel_q;
  assign word_done  = done_q;
  assign word_abort = abort_q;

endmodule

// File: tb/tb_lane_arbiter_8b.sv
module tb_lane_arbiter_8b;

  localparam int NL = 4;

  logic            clk_4f = 1'b0;
  logic            reset;
  logic [NL-1:0]   lane_valid;
  logic [NL*8-1:0] lane_data;
  logic [NL-1:0]   lane_ready;
  logic            valid_out;
  logic [7:0]      data_out;
  logic [1:0]      lane_sel;
  logic            word_done;
  logic            word_abort;

  lane_arbiter_8b #(.NUM_LANES(NL), .BYTES_PER_WORD(4), .SEL_W(2)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .lane_valid(lane_valid),
    .lane_data (lane_data),
    .lane_ready(lane_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .lane_sel  (lane_sel),
    .word_done (word_done),
    .word_abort(word_abort)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] sel;
    logic       done;
    logic       contig;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_cyc = -10;
  int         abort_cnt = 0;

  logic [7:0] src_mem [NL][64];
  int         src_head [NL];
  int         src_tail [NL];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk_4f) begin
    exp_t e;
    cyc++;
    chk("done_and_abort", 32'(word_done & word_abort), 32'd0);
    if (valid_out === 1'b1) begin
      chk("unexpected_byte", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.data));
        chk("lane_sel", 32'(lane_sel), 32'(e.sel));
        chk("word_done", 32'(word_done), 32'(e.done));
        if (e.contig) chk("no_bubble", 32'(cyc), 32'(last_cyc + 1));
      end
      last_cyc = cyc;
    end else begin
      chk("done_without_byte", 32'(word_done), 32'd0);
    end
    if (word_abort === 1'b1) begin
      abort_cnt++;
      chk("abort_follows_byte", 32'(last_cyc), 32'(cyc - 1));
    end
  end

  task automatic drive();
    for (int i = 0; i < NL; i++) begin
      lane_valid[i]      = (src_head[i] < src_tail[i]);
      lane_data[i*8 +: 8] = lane_valid[i] ? src_mem[i][src_head[i]] : 8'h00;
    end
  endtask

  // One clock: sources advance only on bytes the DUT accepted at this edge.
  task automatic step();
    logic [NL-1:0] acc;
    acc = reset ? '0 : (lane_ready & lane_valid);
    @(posedge clk_4f);
    #1;
    for (int i = 0; i < NL; i++) if (acc[i]) src_head[i]++;
    drive();
  endtask

  task automatic load(input int lane, input logic [7:0] b0, input int n);
    for (int k = 0; k < n; k++) begin
      src_mem[lane][src_tail[lane]] = b0 + 8'(k);
      src_tail[lane]++;
    end
    drive();
  endtask

  task automatic push_byte(input int lane, input logic [7:0] b, input bit done, input bit contig);
    exp_t e;
    e.data = b; e.sel = 2'(lane); e.done = done; e.contig = contig;
    exp_q.push_back(e);
  endtask

  task automatic push_word(input int lane, input logic [7:0] b0, input bit contig_first);
    for (int k = 0; k < 4; k++)
      push_byte(lane, b0 + 8'(k), (k == 3), (k == 0) ? contig_first : 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    repeat (6) step();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {19'd0, lane_ready, valid_out, data_out, lane_sel, word_done, word_abort}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int start;
    reset = 1'b1;
    for (int i = 0; i < NL; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    drive();

`ifdef FIXED_PRIO_EN
    // Fixed priority: lane 0 keeps winning while it requests.
    load(0, 8'h01, 8);
    load(3, 8'h31, 4);
    step(); chk_zero("reset_cycle1");
    step(); chk_zero("reset_cycle2");
    reset = 1'b0;
    step();
    chk("first_grant", 32'(lane_ready), 32'h1);
    push_word(0, 8'h01, 1'b0);
    push_word(0, 8'h05, 1'b1);
    push_word(3, 8'h31, 1'b0);
    drain("fixed_drain");
`else
    // Reset with all lanes valid, then continuous requesters 0..3.
    load(0, 8'hA1, 4);
    load(1, 8'h10, 4);
    load(2, 8'h20, 4);
    load(3, 8'h30, 4);
    load(0, 8'h00, 4);
    step(); chk_zero("reset_cycle1");
    step(); chk_zero("reset_cycle2");
    reset = 1'b0;
    step();
    chk("first_grant", 32'(lane_ready), 32'h1);
    push_word(0, 8'hA1, 1'b0);
    push_word(1, 8'h10, 1'b1);
    push_word(2, 8'h20, 1'b1);
    push_word(3, 8'h30, 1'b1);
    push_word(0, 8'h00, 1'b1);
    drain("rr_drain");

    // Single lane re-granted to itself with no bubble.
    load(2, 8'h21, 8);
    push_word(2, 8'h21, 1'b0);
    push_word(2, 8'h25, 1'b1);
    drain("self_regrant_drain");

    // Pointer now at lane 3: it beats lane 0 when both appear together,
    // then wraps to lane 0.
    load(3, 8'h31, 4);
    load(0, 8'h01, 4);
    push_word(3, 8'h31, 1'b0);
    push_word(0, 8'h01, 1'b1);
    drain("ptr_wrap_drain");

    // Lane 1 drops after two bytes: abort, then lane 3 served.
    a0 = abort_cnt;
    load(1, 8'h55, 1);
    load(1, 8'h66, 1);
    load(3, 8'h3A, 4);
    push_byte(1, 8'h55, 1'b0, 1'b0);
    push_byte(1, 8'h66, 1'b0, 1'b1);
    push_word(3, 8'h3A, 1'b0);
    drain("abort_drain");
    chk("abort_count", 32'(abort_cnt - a0), 32'd1);

    // Move the pointer to lane 2, then reset three bytes into a word.
    load(1, 8'h71, 4);
    push_word(1, 8'h71, 1'b0);
    drain("pre_reset_drain");
    a0 = abort_cnt;
    start = src_head[2];
    load(2, 8'hC1, 4);
    push_byte(2, 8'hC1, 1'b0, 1'b0);
    push_byte(2, 8'hC2, 1'b0, 1'b1);
    push_byte(2, 8'hC3, 1'b0, 1'b1);
    for (int n = 0; n < 50; n++) begin
      if (src_head[2] - start >= 3) break;
      step();
    end
    chk("three_bytes_taken", 32'(src_head[2] - start), 32'd3);
    reset = 1'b1;
    step();
    chk_zero("midword_reset");
    src_head[2] = src_tail[2];
    load(0, 8'hD1, 4);
    load(3, 8'hF1, 4);
    step();
    chk_zero("midword_reset_hold");
    chk("no_abort_on_reset", 32'(abort_cnt - a0), 32'd0);
    reset = 1'b0;
    step();
    chk("grant_after_reset", 32'(lane_ready), 32'h1);
    push_word(0, 8'hD1, 1'b0);
    push_word(3, 8'hF1, 1'b1);
    drain("post_reset_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
